// File: rtl/int_pkg.sv
// Shared types and constants for the 6502 interrupt/reset sequencer.
package int_pkg;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        PUSH_PCH,
        PUSH_PCL,
        PUSH_P,
        VEC_LO,
        VEC_HI
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IRQ  = 2'd1,
        SRC_NMI  = 2'd2,
        SRC_RES  = 2'd3
    } src_e;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RES = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    function automatic logic [15:0] vec_base(input src_e s);
        logic [15:0] base;
        case (s)
            SRC_NMI: base = VEC_NMI;
            SRC_RES: base = VEC_RES;
            default: base = VEC_IRQ;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/nmi_edge_det.sv
// Falling-edge detector for the pre-synchronized NMI pin with a sticky pending flag.
module nmi_edge_det (
    input  logic clk1,
    input  logic rst,
    input  logic nmi_n,
    input  logic clr,
    output logic nmi_pend
);

    logic nmi_n_q;
    logic nmi_n_d;
    logic nmi_pend_q;
    logic nmi_pend_d;

    // While pending, further edges are absorbed; only clr can drop the flag.
    always_comb begin
        nmi_n_d    = nmi_n;
        nmi_pend_d = nmi_pend_q ? ~clr : (nmi_n_q & ~nmi_n);
    end

    always_ff @(posedge clk1) begin
        nmi_n_q <= nmi_n_d;
        if (rst) begin
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_pend_q <= nmi_pend_d;
        end
    end

    assign nmi_pend = nmi_pend_q;

endmodule

// File: rtl/int_sequencer.sv
// Interrupt/reset sequencer: forces BRK at an instruction boundary and walks the
// six interrupt cycles (dummy read, push PCH/PCL/P, fetch vector low/high).
module int_sequencer
    import int_pkg::*;
(
    input  logic        clk1,
    input  logic        rst,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        res_n,
    input  logic        iflag,
    input  logic        sync,
    input  logic        rdy,
    output logic        force_brk,
    output logic        pc_hold,
    output logic        push_en,
    output logic        wr_suppress,
    output logic        bflag_clr,
    output logic        vec_en,
    output logic [15:0] vec_addr,
    output logic        set_i,
    output logic        busy,
    output logic [1:0]  src
);

    state_e      state_q;
    state_e      state_d;
    src_e        src_q;
    src_e        src_d;
    logic        res_pend_q;
    logic        res_pend_d;
    logic        nmi_pend;
    logic        nmi_clr;
    logic        irq_req;
    logic        start_brk;
    logic        in_push;
    logic        in_vec;
    logic [15:0] base;

    nmi_edge_det u_nmi_edge_det (
        .clk1     (clk1),
        .rst      (rst),
        .nmi_n    (nmi_n),
        .clr      (nmi_clr),
        .nmi_pend (nmi_pend)
    );

    assign irq_req = ~irq_n & ~iflag;

    // A pending or asserted reset outranks BRK injection at the boundary.
    assign start_brk = (state_q == IDLE) & ~rst & res_n & ~res_pend_q
                     & sync & rdy & (nmi_pend | irq_req);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        res_pend_d = res_pend_q;
        nmi_clr    = 1'b0;
        if (!res_n) begin
            state_d    = IDLE;
            src_d      = SRC_NONE;
            res_pend_d = 1'b1;
        end else if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (res_pend_q) begin
                        state_d    = T1;
                        src_d      = SRC_RES;
                        res_pend_d = 1'b0;
                    end else if (start_brk) begin
                        state_d = T1;
                        src_d   = nmi_pend ? SRC_NMI : SRC_IRQ;
                    end
                end
                T1:       state_d = PUSH_PCH;
                PUSH_PCH: state_d = PUSH_PCL;
                PUSH_PCL: state_d = PUSH_P;
                PUSH_P:   state_d = VEC_LO;
                VEC_LO:   state_d = VEC_HI;
                VEC_HI: begin
                    state_d = IDLE;
                    src_d   = SRC_NONE;
                end
                default: begin
                    state_d = IDLE;
                    src_d   = SRC_NONE;
                end
            endcase
            // NMI may hijack an IRQ sequence up to the vector fetch.
            if ((src_q == SRC_IRQ) && nmi_pend &&
                (state_q inside {T1, PUSH_PCH, PUSH_PCL, PUSH_P})) begin
                src_d = SRC_NMI;
            end
            nmi_clr = (state_q == PUSH_P) && (state_d == VEC_LO) && (src_d == SRC_NMI);
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= SRC_NONE;
            res_pend_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            res_pend_q <= res_pend_d;
        end
    end

    always_comb begin
        in_push     = state_q inside {PUSH_PCH, PUSH_PCL, PUSH_P};
        in_vec      = state_q inside {VEC_LO, VEC_HI};
        base        = vec_base(src_q);
        force_brk   = start_brk;
        pc_hold     = (state_q == T1);
        push_en     = in_push & rdy;
        wr_suppress = in_push & (src_q == SRC_RES);
        bflag_clr   = (state_q == PUSH_P);
        vec_en      = in_vec & rdy;
        set_i       = (state_q == VEC_HI) & rdy;
        busy        = (state_q != IDLE);
        src         = src_q;
        vec_addr    = 16'h0000;
        if (state_q == VEC_LO) begin
            vec_addr = base;
        end else if (state_q == VEC_HI) begin
            vec_addr = {base[15:1], 1'b1};
        end
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer with a per-cycle expected-output scoreboard.
module tb_int_sequencer;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        nmi_n;
    logic        irq_n;
    logic        res_n;
    logic        iflag;
    logic        sync;
    logic        rdy;
    logic        force_brk;
    logic        pc_hold;
    logic        push_en;
    logic        wr_suppress;
    logic        bflag_clr;
    logic        vec_en;
    logic [15:0] vec_addr;
    logic        set_i;
    logic        busy;
    logic [1:0]  src;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [24:0] exp_q[$];
    string       tag_q[$];

    always #5 clk1 = ~clk1;

    int_sequencer dut (
        .clk1        (clk1),
        .rst         (rst),
        .nmi_n       (nmi_n),
        .irq_n       (irq_n),
        .res_n       (res_n),
        .iflag       (iflag),
        .sync        (sync),
        .rdy         (rdy),
        .force_brk   (force_brk),
        .pc_hold     (pc_hold),
        .push_en     (push_en),
        .wr_suppress (wr_suppress),
        .bflag_clr   (bflag_clr),
        .vec_en      (vec_en),
        .vec_addr    (vec_addr),
        .set_i       (set_i),
        .busy        (busy),
        .src         (src)
    );

    // Expected {busy,pc_hold,push_en,wr_suppress,bflag_clr,vec_en,set_i,src,vec_addr}
    // for phase ph (0 idle, 1 T1, 2-4 pushes, 5-6 vector), source s, rdy r.
    function automatic logic [24:0] ev(input int ph, input logic [1:0] s, input logic r);
        logic [15:0] b;
        logic [15:0] a;
        logic        psh;
        b   = (s == 2'd2) ? 16'hFFFA : (s == 2'd3) ? 16'hFFFC : 16'hFFFE;
        a   = (ph == 5) ? b : (ph == 6) ? b + 16'd1 : 16'h0000;
        psh = (ph >= 2) && (ph <= 4);
        return {ph != 0, ph == 1, psh && r, psh && (s == 2'd3), ph == 4,
                (ph >= 5) && r, (ph == 6) && r, (ph == 0) ? 2'd0 : s, a};
    endfunction

    function automatic logic [24:0] obs_w();
        return {busy, pc_hold, push_en, wr_suppress, bflag_clr, vec_en, set_i, src, vec_addr};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #2;
    endtask

    task automatic fb_chk(input string tag, input logic e);
        #1;
        chk(tag, {31'd0, force_brk}, {31'd0, e});
    endtask

    task automatic push_ph(input string tag, input int ph, input logic [1:0] s, input logic r);
        exp_q.push_back(ev(ph, s, r));
        tag_q.push_back($sformatf("%s_ph%0d", tag, ph));
    endtask

    // Full six-cycle sequence then IDLE; phases >= sw report source s_b.
    task automatic push_seq(input string tag, input logic [1:0] s_a, input int sw,
                            input logic [1:0] s_b);
        for (int ph = 1; ph <= 6; ph++) begin
            push_ph(tag, ph, (ph < sw) ? s_a : s_b, 1'b1);
        end
        push_ph(tag, 0, 2'd0, 1'b1);
    endtask

    task automatic step_chk();
        logic [24:0] e;
        string       t;
        tick();
        #1;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_empty: observed %h expected none", obs_w());
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, {7'd0, obs_w()}, {7'd0, e});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step_chk();
        end
    endtask

    initial begin
        rst = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; res_n = 1'b1;
        iflag = 1'b1; sync = 1'b0; rdy = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_state", {7'd0, obs_w()}, {7'd0, ev(0, 2'd0, 1'b1)});
        rst = 1'b0;
        fb_chk("rst_fb", 1'b0);

        // Power-up reset sequence
        push_seq("pwr", 2'd3, 7, 2'd3);
        run(7);

        // IRQ masked, then unmasked
        irq_n = 1'b0; iflag = 1'b1; sync = 1'b1;
        fb_chk("irq_masked_fb", 1'b0);
        tick();
        #1;
        chk("irq_masked_idle", {7'd0, obs_w()}, {7'd0, ev(0, 2'd0, 1'b1)});
        iflag = 1'b0;
        fb_chk("irq_fb", 1'b1);
        push_seq("irq", 2'd1, 7, 2'd1);
        step_chk();
        sync = 1'b0; irq_n = 1'b1;
        run(6);

        // NMI edge together with IRQ: NMI wins, no retrigger while held low
        nmi_n = 1'b0;
        tick();
        irq_n = 1'b0; sync = 1'b1;
        fb_chk("nmi_fb", 1'b1);
        push_seq("nmi", 2'd2, 7, 2'd2);
        step_chk();
        sync = 1'b0; irq_n = 1'b1;
        run(6);
        sync = 1'b1;
        fb_chk("nmi_noretrig_fb", 1'b0);
        tick();
        sync = 1'b0;
        #1;
        chk("nmi_noretrig_idle", {7'd0, obs_w()}, {7'd0, ev(0, 2'd0, 1'b1)});

        // NMI edge during PUSH_PCL hijacks the IRQ vector
        nmi_n = 1'b1; irq_n = 1'b0; sync = 1'b1;
        fb_chk("hj_fb", 1'b1);
        push_seq("hj", 2'd1, 5, 2'd2);
        step_chk();
        sync = 1'b0; irq_n = 1'b1;
        run(2);
        nmi_n = 1'b0;
        run(4);

        // NMI edge during VEC_HI: IRQ vector kept, NMI taken at next sync
        nmi_n = 1'b1; irq_n = 1'b0; sync = 1'b1;
        fb_chk("late_fb", 1'b1);
        push_seq("late", 2'd1, 7, 2'd1);
        step_chk();
        sync = 1'b0; irq_n = 1'b1;
        run(5);
        nmi_n = 1'b0;
        step_chk();
        sync = 1'b1;
        fb_chk("late_nmi_fb", 1'b1);
        push_seq("late_nmi", 2'd2, 7, 2'd2);
        step_chk();
        sync = 1'b0;
        run(6);
        nmi_n = 1'b1;

        // rdy stall for three cycles in PUSH_PCH
        irq_n = 1'b0; sync = 1'b1;
        fb_chk("stall_fb", 1'b1);
        push_ph("stall", 1, 2'd1, 1'b1);
        push_ph("stall", 2, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) push_ph("stall_hold", 2, 2'd1, 1'b0);
        for (int ph = 3; ph <= 6; ph++) push_ph("stall", ph, 2'd1, 1'b1);
        push_ph("stall", 0, 2'd0, 1'b1);
        step_chk();
        sync = 1'b0; irq_n = 1'b1;
        step_chk();
        rdy = 1'b0;
        run(3);
        rdy = 1'b1;
        run(5);

        // RES asserted during PUSH_P aborts; release runs the reset sequence
        irq_n = 1'b0; sync = 1'b1;
        fb_chk("resmid_fb", 1'b1);
        for (int ph = 1; ph <= 4; ph++) push_ph("resmid", ph, 2'd1, 1'b1);
        push_ph("resmid_abort", 0, 2'd0, 1'b1);
        step_chk();
        sync = 1'b0; irq_n = 1'b1;
        run(3);
        res_n = 1'b0;
        step_chk();
        sync = 1'b1; irq_n = 1'b0;
        fb_chk("res_low_fb", 1'b0);
        tick();
        #1;
        chk("res_low_idle", {7'd0, obs_w()}, {7'd0, ev(0, 2'd0, 1'b1)});
        res_n = 1'b1; sync = 1'b0; irq_n = 1'b1;
        push_seq("res", 2'd3, 7, 2'd3);
        run(7);

        // rst mid-sequence overrides, then reset sequence follows
        irq_n = 1'b0; sync = 1'b1;
        fb_chk("rstmid_fb", 1'b1);
        push_ph("rstmid", 1, 2'd1, 1'b1);
        step_chk();
        sync = 1'b0; irq_n = 1'b1; rst = 1'b1;
        push_ph("rstmid_abort", 0, 2'd0, 1'b1);
        step_chk();
        rst = 1'b0;
        push_seq("rstseq", 2'd3, 7, 2'd3);
        run(7);

        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL sb_leftover: observed %0d entries expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
